rc5_core_param: RTL

RC5_CORE_PARAM -- requirements
Module: rc5_core_param

---
 rtl/rc5_pkg.sv | 30 +++
 rtl/rc5_half_round.sv | 39 +++
 rtl/rc5_core_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rc5_pkg.sv
// Shared definitions for the RC5 core: FSM states, mode encoding, parameter limits.
package rc5_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRE    = 3'd1,
        ST_HALF_A = 3'd2,
        ST_HALF_B = 3'd3,
        ST_OUT    = 3'd4
    } rc5_state_e;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } rc5_mode_e;

    localparam int R_MIN = 1;
    localparam int R_MAX = 12;

    // Word widths the datapath supports.
    function automatic bit rc5_w_legal(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    // Round counts the datapath supports.
    function automatic bit rc5_r_legal(input int r);
        return (r >= R_MIN) && (r <= R_MAX);
    endfunction

endpackage

// File: rtl/rc5_half_round.sv
// One RC5 half-round on a W-bit word.
// Encrypt: res = ((x ^ y) <<< y) + k
// Decrypt: res = ((x - k) >>> y) ^ y
// x is the word being updated, y the controlling word, k the subkey.
module rc5_half_round
    import rc5_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] k,
    input  logic         dir,
    output logic [W-1:0] res
);

    localparam int LW = $clog2(W);

    logic [LW-1:0] amt_s;
    logic [W-1:0]  mix_s;
    logic [W-1:0]  rot_l_s;
    logic [W-1:0]  sub_s;
    logic [W-1:0]  rot_r_s;

    // Forward and inverse paths; a shift by W yields zero, so amount 0 is identity.
    always_comb begin
        amt_s   = y[LW-1:0];
        mix_s   = x ^ y;
        rot_l_s = (mix_s << amt_s) | (mix_s >> (W - int'(amt_s)));
        sub_s   = x - k;
        rot_r_s = (sub_s >> amt_s) | (sub_s << (W - int'(amt_s)));
        if (dir == MODE_DEC) begin
            res = rot_r_s ^ y;
        end else begin
            res = rot_l_s + k;
        end
    end

endmodule

// File: rtl/rc5_core_param.sv
// Iterative RC5 block cipher core: one half-round per cycle, fixed 2R+2 latency.
module rc5_core_param
    import rc5_pkg::*;
#(
    parameter int W = 8,
    parameter int R = 1,
    localparam int T  = 2 * R + 2,
    localparam int AW = $clog2(T)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            key_wr_en,
    input  logic [AW-1:0]   key_wr_addr,
    input  logic [W-1:0]    key_wr_data,
    input  logic            start,
    input  logic            mode,
    input  logic [2*W-1:0]  in_data,
    output logic            ready,
    output logic [2*W-1:0]  out_data,
    output logic            done
);

    // Round counter width; AW is always CW+1, so {i,1'b0}/{i,1'b1} index S[2i]/S[2i+1].
    localparam int CW = $clog2(R + 1);
    localparam logic [CW-1:0] ROUND_ZERO = CW'(0);
    localparam logic [CW-1:0] ROUND_ONE  = CW'(1);
    localparam logic [CW-1:0] ROUND_LAST = CW'(R);

    if (!rc5_w_legal(W) || !rc5_r_legal(R)) begin : g_param_check
        $error("rc5_core_param: unsupported W or R");
    end

    rc5_state_e    state_r, state_nxt_s;
    rc5_mode_e     mode_r, mode_nxt_s;
    logic [W-1:0]  a_r, b_r, a_nxt_s, b_nxt_s;
    logic [CW-1:0] round_r, round_nxt_s;
    logic [W-1:0]  subkey_r [T];
    logic          key_we_s;
    logic [AW-1:0] idx_a_s, idx_b_s;
    logic [W-1:0]  hr_x_s, hr_y_s, hr_k_s, hr_res_s;
    logic [2*W-1:0] out_data_r;
    logic          done_r, ready_r;

    assign key_we_s = key_wr_en && (state_r == ST_IDLE) &&
                      ({1'b0, key_wr_addr} < (AW + 1)'(T));
    assign idx_a_s  = {round_r, 1'b0};
    assign idx_b_s  = {round_r, 1'b1};

    // Subkey table: cleared by reset, writable only while idle and in range.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < T; i++) begin
                subkey_r[i] <= {W{1'b0}};
            end
        end else if (key_we_s) begin
            subkey_r[key_wr_addr] <= key_wr_data;
        end
    end

    // Route A or B half of the round through the shared half-round unit.
    always_comb begin
        hr_x_s = a_r;
        hr_y_s = b_r;
        hr_k_s = subkey_r[idx_a_s];
        if (state_r == ST_HALF_B) begin
            hr_x_s = b_r;
            hr_y_s = a_r;
            hr_k_s = subkey_r[idx_b_s];
        end else begin
            hr_x_s = a_r;
            hr_y_s = b_r;
            hr_k_s = subkey_r[idx_a_s];
        end
    end

    rc5_half_round #(
        .W (W)
    ) u_half_round (
        .x   (hr_x_s),
        .y   (hr_y_s),
        .k   (hr_k_s),
        .dir (mode_r),
        .res (hr_res_s)
    );

    // Next-state and datapath update for the sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        mode_nxt_s  = mode_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        round_nxt_s = round_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_nxt_s = rc5_mode_e'(mode);
                    a_nxt_s    = in_data[2*W-1:W];
                    b_nxt_s    = in_data[W-1:0];
                    if (mode == MODE_DEC) begin
                        state_nxt_s = ST_HALF_B;
                        round_nxt_s = ROUND_LAST;
                    end else begin
                        state_nxt_s = ST_PRE;
                        round_nxt_s = ROUND_ONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (mode_r == MODE_DEC) begin
                    a_nxt_s     = a_r - subkey_r[0];
                    b_nxt_s     = b_r - subkey_r[1];
                    state_nxt_s = ST_OUT;
                end else begin
                    a_nxt_s     = a_r + subkey_r[0];
                    b_nxt_s     = b_r + subkey_r[1];
                    state_nxt_s = ST_HALF_A;
                end
            end
            ST_HALF_A: begin
                a_nxt_s = hr_res_s;
                if (mode_r == MODE_DEC) begin
                    if (round_r == ROUND_ONE) begin
                        state_nxt_s = ST_PRE;
                    end else begin
                        state_nxt_s = ST_HALF_B;
                        round_nxt_s = round_r - ROUND_ONE;
                    end
                end else begin
                    state_nxt_s = ST_HALF_B;
                end
            end
            ST_HALF_B: begin
                b_nxt_s = hr_res_s;
                if (mode_r == MODE_DEC) begin
                    state_nxt_s = ST_HALF_A;
                end else if (round_r == ROUND_LAST) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = ST_HALF_A;
                    round_nxt_s = round_r + ROUND_ONE;
                end
            end
            ST_OUT: begin
                state_nxt_s = ST_IDLE;
                round_nxt_s = ROUND_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                round_nxt_s = ROUND_ZERO;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Working registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_r     <= MODE_ENC;
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            round_r    <= ROUND_ZERO;
            out_data_r <= {(2 * W){1'b0}};
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            mode_r  <= mode_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            round_r <= round_nxt_s;
            if (state_r == ST_OUT) begin
                out_data_r <= {a_r, b_r};
            end
            done_r  <= (state_r == ST_OUT);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    assign ready    = ready_r;
    assign out_data = out_data_r;
    assign done     = done_r;

endmodule
